cadeado_param: RTL

Parametrised, clocked combination lock for the lab's digital-lock exercises. It replaces edge-counting on raw inputs with a keypad interface: a digit-entry buffer, a programmable stored code, a failed-attempt counter with timed lockout, and a timed open window. It sits between a debounced keypad front end, which supplies one-cycle key strobes, and the lock actuator or status LEDs.

---
 rtl/cadeado_pkg.sv | 18 +
 rtl/cadeado_timer.sv | 37 +++
 rtl/cadeado_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cadeado_pkg.sv
// cadeado_pkg
//   Shared definitions for the cadeado keypad lock.
//   - state_t : 2-bit FSM state encoding (LOCKED, OPEN, PROG, LOCKOUT)
//   - clog2p1 : width needed to hold values 0..x, i.e. $clog2(x+1)
package cadeado_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        PROG    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    function automatic int clog2p1(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/cadeado_timer.sv
// cadeado_timer
//   Saturating down-counter shared by the timed states of the lock.
//   Ports:
//     clk      in  : rising-edge clock
//     rst_n    in  : synchronous active-low reset
//     load     in  : load load_val this cycle (overrides counting)
//     load_val in  : value to load, 0..MAX
//     done     out : counter has reached zero
module cadeado_timer
    import cadeado_pkg::*;
#(
    parameter int MAX = 1,
    localparam int W  = clog2p1(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Counts down to zero and holds there; a load restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/cadeado_param.sv
// cadeado_param
//   Keypad combination lock: digit-entry buffer, programmable code,
//   failed-attempt counter with timed lockout and a timed open window.
//   Ports:
//     clk        in  : rising-edge clock
//     rst_n      in  : synchronous active-low reset
//     key_valid  in  : one-cycle strobe, key_data valid
//     key_data   in  : digit value (DIG_W bits)
//     key_clear  in  : abort current entry
//     prog_req   in  : request code change (only honoured while open)
//     aberto     out : lock open (OPEN or PROG)
//     bloqueado  out : lockout active
//     erro       out : one-cycle pulse on a wrong code
//     tentativas out : consecutive failed attempts
module cadeado_param
    import cadeado_pkg::*;
#(
    parameter int                        DIGITS       = 4,
    parameter int                        DIG_W        = 4,
    parameter logic [DIGITS*DIG_W-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                        MAX_TRIES    = 3,
    parameter int                        LOCKOUT_CYC  = 1000,
    parameter int                        OPEN_CYC     = 500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           key_valid,
    input  logic [DIG_W-1:0]               key_data,
    input  logic                           key_clear,
    input  logic                           prog_req,
    output logic                           aberto,
    output logic                           bloqueado,
    output logic                           erro,
    output logic [clog2p1(MAX_TRIES)-1:0]  tentativas
);

    localparam int CODE_W  = DIGITS * DIG_W;
    localparam int CNT_W   = clog2p1(DIGITS);
    localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = clog2p1(TMR_MAX);

    state_t                   state;
    state_t                   state_next;
    logic [CODE_W-1:0]        buffer;
    logic [CODE_W-1:0]        code;
    logic [CODE_W-1:0]        shifted;
    logic [CODE_W+DIG_W-1:0]  extended;
    logic [CNT_W-1:0]         count;
    logic                     digit_take;
    logic                     last_digit;
    logic                     code_match;
    logic                     timer_load;
    logic [TMR_W-1:0]         timer_val;
    logic                     timer_done;
    logic                     aberto_d;
    logic                     bloqueado_d;
    logic                     erro_d;

    // Shift the new digit in at the LSB end; after DIGITS digits the first
    // one sits in the MSBs. Building the wider vector first keeps this legal
    // for DIGITS == 1.
    assign extended   = {buffer, key_data};
    assign shifted    = extended[CODE_W-1:0];

    // A simultaneous clear beats the strobe, so the digit is dropped.
    assign digit_take = key_valid && !key_clear && (state == LOCKED || state == PROG);
    assign last_digit = digit_take && (count == CNT_W'(DIGITS - 1));
    assign code_match = (shifted == code);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            LOCKED: begin
                if (last_digit) begin
                    if (code_match) begin
                        state_next = OPEN;
                    end else if (tentativas == $bits(tentativas)'(MAX_TRIES - 1)) begin
                        state_next = LOCKOUT;
                    end
                end
            end
            OPEN: begin
                // prog_req wins over a simultaneous window expiry.
                if (prog_req) begin
                    state_next = PROG;
                end else if (timer_done) begin
                    state_next = LOCKED;
                end
            end
            PROG: begin
                // A digit in the expiry cycle restarts the idle timer.
                if (key_clear || last_digit) begin
                    state_next = LOCKED;
                end else if (!digit_take && timer_done) begin
                    state_next = LOCKED;
                end
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_next = LOCKED;
                end
            end
            default: state_next = LOCKED;
        endcase
    end

    // Output logic; the values are registered below so all outputs change
    // on the same edge as the state they describe.
    always_comb begin
        aberto_d    = (state_next == OPEN) || (state_next == PROG);
        bloqueado_d = (state_next == LOCKOUT);
        erro_d      = (state == LOCKED) && last_digit && !code_match;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aberto    <= 1'b0;
            bloqueado <= 1'b0;
            erro      <= 1'b0;
        end else begin
            aberto    <= aberto_d;
            bloqueado <= bloqueado_d;
            erro      <= erro_d;
        end
    end

    // The timer is loaded with N-1 because done is seen one cycle before the
    // leaving edge, which gives exactly N cycles in the state.
    assign timer_load = (state_next != state) || (state == PROG && digit_take);
    assign timer_val  = (state_next == LOCKOUT) ? TMR_W'(LOCKOUT_CYC - 1)
                                                : TMR_W'(OPEN_CYC - 1);

    cadeado_timer #(
        .MAX (TMR_MAX)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Entry buffer and digit count; emptied on every compare, every clear
    // and every state change so each state starts with a fresh entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer <= '0;
            count  <= '0;
        end else if (key_clear || last_digit || (state_next != state)) begin
            buffer <= '0;
            count  <= '0;
        end else if (digit_take) begin
            buffer <= shifted;
            count  <= count + CNT_W'(1);
        end
    end

    // Stored code and failed-attempt counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code       <= DEFAULT_CODE;
            tentativas <= '0;
        end else begin
            if (state == PROG && last_digit) begin
                code <= shifted;
            end
            if (state == LOCKED && last_digit) begin
                tentativas <= code_match ? '0 : tentativas + 1'b1;
            end else if (state == LOCKOUT && state_next == LOCKED) begin
                tentativas <= '0;
            end
        end
    end

endmodule
